hamming_2d_decoder: RTL and testbench

HAMMING_2D_DECODER -- requirements
Module: hamming_2d_decoder

---
 rtl/hamming_2d_decoder.sv | 128 ++++++++++++
 tb/tb_hamming_2d_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_2d_decoder.sv
// Decodes four Hamming(15,11) column codewords into a 4x4 row-bit block, one column per cycle.
// Capture to out_valid in 5 cycles; the result is held until out_ready, and in_ready stays low until then.
module hamming_2d_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] encoded_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] row_bits,
  output logic [3:0]  corr_mask,
  output logic [3:0]  pad_err,
  output logic [15:0] corr_count
);

  typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

  // Codeword bits holding d0..d6 (positions 3,5,6,7,9,10,11).
  localparam logic [14:0] PAD_MASK = 15'h0774;

  state_t      state_q, state_d;
  logic [59:0] word_q, word_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] row_bits_q, row_bits_d;
  logic [3:0]  corr_mask_q, corr_mask_d;
  logic [3:0]  pad_err_q, pad_err_d;
  logic [15:0] corr_count_q, corr_count_d;

  logic [14:0] col_word;
  logic [3:0]  syndrome;
  logic [14:0] flip;
  logic [3:0]  col_data;
  logic        pad_nz;
  logic [2:0]  fix_count;
  logic [16:0] count_sum;

  always_comb begin
    case (col_q)
      2'd0:    col_word = word_q[14:0];
      2'd1:    col_word = word_q[29:15];
      2'd2:    col_word = word_q[44:30];
      default: col_word = word_q[59:45];
    endcase
  end

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < 15; k++) begin
      if (col_word[k]) syndrome = syndrome ^ 4'(k + 1);
    end
    flip     = (syndrome != 4'd0) ? (15'd1 << (syndrome - 4'd1)) : 15'd0;
    col_data = col_word[14:11] ^ flip[14:11];
    pad_nz   = |((col_word ^ flip) & PAD_MASK);
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    col_d        = col_q;
    row_bits_d   = row_bits_q;
    corr_mask_d  = corr_mask_q;
    pad_err_d    = pad_err_q;
    corr_count_d = corr_count_q;
    fix_count    = '0;
    count_sum    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d      = encoded_in;
          col_d       = 2'd0;
          row_bits_d  = '0;
          corr_mask_d = '0;
          pad_err_d   = '0;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        for (int r = 0; r < 4; r++) begin
          row_bits_d[{2'(r), col_q}] = col_data[r];
        end
        corr_mask_d[col_q] = (syndrome != 4'd0);
        pad_err_d[col_q]   = pad_nz;
        col_d              = col_q + 2'd1;
        if (col_q == 2'd3) begin
          for (int i = 0; i < 4; i++) begin
            fix_count = fix_count + {2'b00, corr_mask_d[i]};
          end
          count_sum    = {1'b0, corr_count_q} + {14'd0, fix_count};
          corr_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      col_q        <= '0;
      row_bits_q   <= '0;
      corr_mask_q  <= '0;
      pad_err_q    <= '0;
      corr_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      col_q        <= col_d;
      row_bits_q   <= row_bits_d;
      corr_mask_q  <= corr_mask_d;
      pad_err_q    <= pad_err_d;
      corr_count_q <= corr_count_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign row_bits   = row_bits_q;
  assign corr_mask  = corr_mask_q;
  assign pad_err    = pad_err_q;
  assign corr_count = corr_count_q;

endmodule

// File: tb/tb_hamming_2d_decoder.sv
// Directed bench for hamming_2d_decoder: hand-encoded column words with known rows, errors and pads.
module tb_hamming_2d_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] encoded_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] row_bits;
  logic [3:0]  corr_mask;
  logic [3:0]  pad_err;
  logic [15:0] corr_count;

  int checks = 0;
  int errors = 0;

  // Rows 0x1,0x2,0x4,0x8 -> columns carry d7,d8,d9,d10 respectively.
  localparam logic [59:0] CLEAN    = {15'h408B, 15'h208A, 15'h1089, 15'h0888};
  localparam logic [59:0] SINGLE   = CLEAN ^ (60'd1 << 35);
  localparam logic [59:0] FOUR_ERR = CLEAN ^ {15'h4000, 15'h0001, 15'h0200, 15'h0004};
  localparam logic [59:0] PAD      = {15'h408B, 15'h208A, 15'h1089, 15'h088F};
  localparam logic [59:0] ONES     = {60{1'b1}};
  // Row3 bit0 and row1 bit3 set; column 3 has its position-1 parity bit flipped.
  localparam logic [59:0] MAP_ERR  = {15'h1088, 15'h0000, 15'h0000, 15'h408B};

  always #5 clk = ~clk;

  hamming_2d_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .encoded_in (encoded_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .row_bits   (row_bits),
    .corr_mask  (corr_mask),
    .pad_err    (pad_err),
    .corr_count (corr_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture w in IDLE and advance through the four decode edges; leaves the bench in HOLD.
  task automatic send(input logic [59:0] w);
    in_valid   = 1'b1;
    encoded_in = w;
    tick();
    in_valid   = 1'b0;
    encoded_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; encoded_in = ONES;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (row_bits !== 16'h0000) begin errors++; $display("FAIL reset_row_bits: got %h expected 0000", row_bits); end
    checks++; if (corr_mask !== 4'h0 || pad_err !== 4'h0) begin errors++; $display("FAIL reset_flags: got mask %b pad %b expected 0000 0000", corr_mask, pad_err); end
    checks++; if (corr_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", corr_count); end
  endtask

  task automatic test_clean();
    out_ready = 1'b1;
    in_valid = 1'b1; encoded_in = CLEAN;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clean_busy: got in_ready %b expected 0", in_ready); end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_early: got out_valid %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency: got out_valid %b expected 1", out_valid); end
    checks++; if (row_bits !== 16'h8421) begin errors++; $display("FAIL clean_rows: got %h expected 8421", row_bits); end
    checks++; if (corr_mask !== 4'b0000 || pad_err !== 4'b0000) begin errors++; $display("FAIL clean_flags: got mask %b pad %b expected 0000 0000", corr_mask, pad_err); end
    checks++; if (corr_count !== 16'd0) begin errors++; $display("FAIL clean_count: got %0d expected 0", corr_count); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL clean_release: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_single_error();
    send(SINGLE);
    checks++; if (row_bits !== 16'h8421) begin errors++; $display("FAIL single_rows: got %h expected 8421", row_bits); end
    checks++; if (corr_mask !== 4'b0100) begin errors++; $display("FAIL single_mask: got %b expected 0100", corr_mask); end
    checks++; if (corr_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", corr_count); end
    tick();
  endtask

  task automatic test_four_errors();
    send(FOUR_ERR);
    checks++; if (row_bits !== 16'h8421) begin errors++; $display("FAIL four_rows: got %h expected 8421", row_bits); end
    checks++; if (corr_mask !== 4'b1111 || pad_err !== 4'b0000) begin errors++; $display("FAIL four_flags: got mask %b pad %b expected 1111 0000", corr_mask, pad_err); end
    checks++; if (corr_count !== 16'd5) begin errors++; $display("FAIL four_count: got %0d expected 5", corr_count); end
    tick();
  endtask

  task automatic test_pad();
    send(PAD);
    checks++; if (pad_err !== 4'b0001 || corr_mask !== 4'b0000) begin errors++; $display("FAIL pad_flags: got pad %b mask %b expected 0001 0000", pad_err, corr_mask); end
    checks++; if (row_bits !== 16'h8421) begin errors++; $display("FAIL pad_rows: got %h expected 8421", row_bits); end
    tick();
    send(ONES);
    checks++; if (row_bits !== 16'hFFFF || pad_err !== 4'b1111 || corr_mask !== 4'b0000) begin errors++; $display("FAIL ones_result: got rows %h pad %b mask %b expected FFFF 1111 0000", row_bits, pad_err, corr_mask); end
    checks++; if (corr_count !== 16'd5) begin errors++; $display("FAIL ones_count: got %0d expected 5", corr_count); end
    tick();
  endtask

  task automatic test_mapping();
    send(MAP_ERR);
    checks++; if (row_bits !== 16'h1080) begin errors++; $display("FAIL map_rows: got %h expected 1080", row_bits); end
    checks++; if (corr_mask !== 4'b1000 || pad_err !== 4'b0000) begin errors++; $display("FAIL map_flags: got mask %b pad %b expected 1000 0000", corr_mask, pad_err); end
    checks++; if (corr_count !== 16'd6) begin errors++; $display("FAIL map_count: got %0d expected 6", corr_count); end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send(CLEAN);
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_hs_%0d: got out_valid %b in_ready %b expected 1 0", i, out_valid, in_ready); end
      checks++; if (row_bits !== 16'h8421 || corr_mask !== 4'b0000 || pad_err !== 4'b0000) begin errors++; $display("FAIL hold_data_%0d: got rows %h mask %b pad %b expected 8421 0000 0000", i, row_bits, corr_mask, pad_err); end
      if (i == 3) begin in_valid = 1'b1; encoded_in = ONES; end
      tick();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_ignored_%0d: got out_valid %b in_ready %b expected 0 1", i, out_valid, in_ready); end
    end
    checks++; if (corr_count !== 16'd6) begin errors++; $display("FAIL hold_count: got %0d expected 6", corr_count); end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; encoded_in = FOUR_ERR;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++; if (out_valid !== ((e == 4) || (e == 10))) begin errors++; $display("FAIL b2b_valid_%0d: got %b expected %b", e, out_valid, ((e == 4) || (e == 10))); end
      if (e == 11) in_valid = 1'b0;
    end
    checks++; if (corr_count !== 16'd14) begin errors++; $display("FAIL b2b_count: got %0d expected 14", corr_count); end
  endtask

  task automatic test_saturation();
    force dut.corr_count_q = 16'hFFF8;
    tick();
    release dut.corr_count_q;
    send(FOUR_ERR);
    checks++; if (corr_count !== 16'hFFFC) begin errors++; $display("FAIL sat_near: got %h expected FFFC", corr_count); end
    tick();
    send(FOUR_ERR);
    checks++; if (corr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected FFFF", corr_count); end
    tick();
    send(FOUR_ERR);
    checks++; if (corr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected FFFF", corr_count); end
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; encoded_in = FOUR_ERR;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (corr_mask !== 4'b0011) begin errors++; $display("FAIL mid_partial: got mask %b expected 0011", corr_mask); end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || row_bits !== 16'h0000 || corr_mask !== 4'h0 || pad_err !== 4'h0) begin errors++; $display("FAIL mid_cleared: got valid %b rows %h mask %b pad %b expected 0 0000 0000 0000", out_valid, row_bits, corr_mask, pad_err); end
    checks++; if (corr_count !== 16'h0000) begin errors++; $display("FAIL mid_count: got %h expected 0000", corr_count); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || corr_count !== 16'h0000) begin errors++; $display("FAIL mid_aborted_%0d: got valid %b count %h expected 0 0000", i, out_valid, corr_count); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_four_errors();
    test_pad();
    test_mapping();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
